// File: rtl/serial_rx_deframer_if.sv
// Avalon-ST byte stream carrying deframed payload, with packet delimiters and error flag.
interface serial_rx_deframer_if;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       out_startofpacket;
   logic       out_endofpacket;
   logic       out_error;

   modport master (
      output out_data, out_valid, out_startofpacket, out_endofpacket, out_error,
      input  out_ready
   );

   modport slave (
      input  out_data, out_valid, out_startofpacket, out_endofpacket, out_error,
      output out_ready
   );
endinterface

// File: rtl/serial_rx_deframer.sv
// Serial receive deframer: sync hunt, LEN/payload/checksum parsing, payload FIFO
// onto Avalon-ST, and saturating good/bad frame statistics.
module serial_rx_deframer #(
   parameter logic [31:0] SYNC_WORD  = 32'hA5C3_3C5A,
   parameter int          FIFO_DEPTH = 16,
   parameter int          CNT_W      = 16
) (
   input  logic                 clk_clk,
   input  logic                 reset_reset_n,
   input  logic                 serial_data,
   input  logic                 bit_valid,
   input  logic                 clear_stats,
   serial_rx_deframer_if.master st,
   output logic                 locked,
   output logic [CNT_W-1:0]     good_frames,
   output logic [CNT_W-1:0]     bad_frames,
   output logic                 overflow,
   output logic [7:0]           led_readdata
);
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_HUNT    = 2'd0,
      ST_LEN     = 2'd1,
      ST_PAYLOAD = 2'd2,
      ST_CSUM    = 2'd3
   } state_t;

   function automatic logic [7:0] csum_add(input logic [7:0] a, input logic [7:0] b);
      return a + b;
   endfunction

   state_t       state_r, state_s;
   logic [31:0]  shift_r, shift_s, shifted_s;
   logic [2:0]   bit_cnt_r, bit_cnt_s;
   logic [7:0]   len_r, len_s, byte_cnt_r, byte_cnt_s, sum_r, sum_s, held_r, held_s, byte_s;
   logic         push_r, push_s;
   logic [10:0]  push_entry_r, push_entry_s;
   logic         frame_done_s, frame_ok_s;

   logic [10:0]  mem_r [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_r, rd_ptr_r;
   logic [AW:0]  count_r;
   logic         empty_s, full_s, pop_s, wr_en_s, drop_s;
   logic [10:0]  head_s;

   logic [CNT_W-1:0] good_r, bad_r;
   logic             ovf_r;

   assign shifted_s = {shift_r[30:0], serial_data};
   assign byte_s    = {shift_r[6:0], serial_data};

   // Next-state and datapath decode; every field completes on its eighth strobed bit
   always_comb begin
      state_s      = state_r;
      shift_s      = shift_r;
      bit_cnt_s    = bit_cnt_r;
      len_s        = len_r;
      byte_cnt_s   = byte_cnt_r;
      sum_s        = sum_r;
      held_s       = held_r;
      push_s       = 1'b0;
      push_entry_s = push_entry_r;
      frame_done_s = 1'b0;
      frame_ok_s   = 1'b0;
      if (bit_valid) begin
         shift_s   = shifted_s;
         bit_cnt_s = bit_cnt_r + 3'd1;
         case (state_r)
            ST_HUNT: begin
               if (shifted_s == SYNC_WORD) begin
                  state_s   = ST_LEN;
                  bit_cnt_s = 3'd0;
               end else begin
                  state_s = ST_HUNT;
               end
            end
            ST_LEN: begin
               if (bit_cnt_r == 3'd7) begin
                  len_s      = byte_s;
                  sum_s      = byte_s;
                  byte_cnt_s = byte_s;
                  state_s    = (byte_s == 8'd0) ? ST_CSUM : ST_PAYLOAD;
               end else begin
                  state_s = ST_LEN;
               end
            end
            ST_PAYLOAD: begin
               if (bit_cnt_r == 3'd7) begin
                  sum_s      = csum_add(sum_r, byte_s);
                  byte_cnt_s = byte_cnt_r - 8'd1;
                  // The final byte waits for the checksum so it can carry eop/err
                  if (byte_cnt_r == 8'd1) begin
                     held_s  = byte_s;
                     state_s = ST_CSUM;
                  end else begin
                     push_s       = 1'b1;
                     push_entry_s = {1'b0, 1'b0, (byte_cnt_r == len_r), byte_s};
                  end
               end else begin
                  state_s = ST_PAYLOAD;
               end
            end
            ST_CSUM: begin
               if (bit_cnt_r == 3'd7) begin
                  frame_done_s = 1'b1;
                  frame_ok_s   = (byte_s == sum_r);
                  push_s       = (len_r != 8'd0);
                  push_entry_s = {~frame_ok_s, 1'b1, (len_r == 8'd1), held_r};
                  shift_s      = 32'd0;
                  state_s      = ST_HUNT;
               end else begin
                  state_s = ST_CSUM;
               end
            end
            default: begin
               state_s = ST_HUNT;
            end
         endcase
      end else begin
         shift_s = shift_r;
      end
   end

   // Framer state and datapath registers
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         state_r      <= ST_HUNT;
         shift_r      <= 32'd0;
         bit_cnt_r    <= 3'd0;
         len_r        <= 8'd0;
         byte_cnt_r   <= 8'd0;
         sum_r        <= 8'd0;
         held_r       <= 8'd0;
         push_r       <= 1'b0;
         push_entry_r <= 11'd0;
      end else begin
         state_r      <= state_s;
         shift_r      <= shift_s;
         bit_cnt_r    <= bit_cnt_s;
         len_r        <= len_s;
         byte_cnt_r   <= byte_cnt_s;
         sum_r        <= sum_s;
         held_r       <= held_s;
         push_r       <= push_s;
         push_entry_r <= push_entry_s;
      end
   end

   assign empty_s = (count_r == {(AW+1){1'b0}});
   assign full_s  = (count_r == (AW+1)'(FIFO_DEPTH));
   assign pop_s   = ~empty_s & st.out_ready;
   // A pop frees the slot in the same cycle, so a full FIFO can still accept
   assign wr_en_s = push_r & (~full_s | pop_s);
   assign drop_s  = push_r & full_s & ~pop_s;

   // FIFO storage; unwritten entries are never observed because outputs are gated by empty
   always_ff @(posedge clk_clk) begin
      if (wr_en_s) begin
         mem_r[wr_ptr_r] <= push_entry_r;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {(AW+1){1'b0}};
      end else begin
         if (wr_en_s) wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
         if (pop_s)   rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
         case ({wr_en_s, pop_s})
            2'b10:   count_r <= count_r + {{AW{1'b0}}, 1'b1};
            2'b01:   count_r <= count_r - {{AW{1'b0}}, 1'b1};
            default: count_r <= count_r;
         endcase
      end
   end

   // Frame statistics; clear_stats takes priority over a coincident increment
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         good_r <= {CNT_W{1'b0}};
         bad_r  <= {CNT_W{1'b0}};
         ovf_r  <= 1'b0;
      end else if (clear_stats) begin
         good_r <= {CNT_W{1'b0}};
         bad_r  <= {CNT_W{1'b0}};
         ovf_r  <= 1'b0;
      end else begin
         if (frame_done_s && frame_ok_s && (good_r != {CNT_W{1'b1}}))
            good_r <= good_r + CNT_W'(1);
         if (frame_done_s && !frame_ok_s && (bad_r != {CNT_W{1'b1}}))
            bad_r <= bad_r + CNT_W'(1);
         if (drop_s)
            ovf_r <= 1'b1;
      end
   end

   // Output decode from registered FIFO head
   always_comb begin
      head_s = 11'd0;
      if (!empty_s) begin
         head_s = mem_r[rd_ptr_r];
      end else begin
         head_s = 11'd0;
      end
   end

   assign st.out_valid         = ~empty_s;
   assign st.out_data          = head_s[7:0];
   assign st.out_startofpacket = head_s[8];
   assign st.out_endofpacket   = head_s[9];
   assign st.out_error         = head_s[10];
   assign locked               = (state_r != ST_HUNT);
   assign good_frames          = good_r;
   assign bad_frames           = bad_r;
   assign overflow             = ovf_r;
   assign led_readdata         = good_r[7:0];
endmodule

// File: doc/serial_rx_deframer.md
Name: serial_rx_deframer

Overview:
- Receive-side companion to the tx_0 serial transmitter; consumes the bitstream on tx_serial_data (loopback or far-end board over HSMC).
- Hunts for a sync word and deserializes MSB-first bytes.
- Checks the length and the 8-bit additive checksum.
- Delivers payload bytes on an Avalon-ST source through a small FIFO; good/bad frame counters feed the LED status register.

Parameters:
- SYNC_WORD, 32'hA5C3_3C5A, frame sync pattern, MSB first.
- FIFO_DEPTH, 16, output FIFO entries; power of two, minimum 4.
- CNT_W, 16, width of the saturating frame counters.

Ports:
- clk_clk  in  1  sole clock.
- reset_reset_n  in  1  synchronous, active-low reset.
- serial_data  in  1  received bit.
- bit_valid  in  1  serial_data sampled only when 1 (rate strobe).
- out_data  out  8  payload byte.
- out_valid  out  1  Avalon-ST valid.
- out_ready  in  1  Avalon-ST ready; readyLatency 0.
- out_startofpacket  out  1  first payload byte of a frame.
- out_endofpacket  out  1  last payload byte of a frame.
- out_error  out  1  valid with endofpacket; 1 = checksum mismatch.
- clear_stats  in  1  synchronous clear of counters and sticky flags.
- locked  out  1  1 while in LEN/PAYLOAD/CSUM.
- good_frames  out  CNT_W  saturating good-frame count.
- bad_frames  out  CNT_W  saturating bad-frame count.
- overflow  out  1  sticky: a byte was dropped on a full FIFO.
- led_readdata  out  8  equals good_frames[7:0].

Behaviour:
- Reset (reset_reset_n=0 at a clk edge):
  - State returns to HUNT; FIFO, shift register and counters are cleared.
  - All outputs are 0.
  - A frame in progress is abandoned, with no output and no counter change.
- Framing: 32-bit SYNC_WORD, then LEN (8 bit), then LEN payload bytes, then CSUM.
  - CSUM = (LEN + sum of payload) mod 256.
  - All fields MSB first.
  - Bits advance only on cycles with bit_valid=1.
- FSM:
  - HUNT: shift serial_data into a 32-bit register. If the register value including the current bit equals SYNC_WORD, go to LEN and clear the bit counter. Sync overlap with data is not filtered.
  - LEN: collect 8 bits, latch LEN and seed the sum with LEN. LEN=0 goes to CSUM; otherwise go to PAYLOAD with the byte counter set to LEN.
  - PAYLOAD: on each completed byte, add it to the sum.
    - Bytes 1..LEN-1: push to the FIFO the cycle after the last bit, with sop=1 on byte 1.
    - Last byte: held in a register, not pushed; go to CSUM.
  - CSUM: collect 8 bits and compare with the sum.
    - LEN>0: push the held byte with eop=1 and err=(mismatch); sop=1 as well when LEN=1.
    - Any LEN: increment good_frames on match, else bad_frames.
    - Return to HUNT with the shift register cleared.
- FIFO: entries are {err, eop, sop, data}. out_valid = not empty.
  - Pop on out_valid & out_ready.
  - Simultaneous push and pop is allowed when full (net count unchanged).
  - A push into a full FIFO without a pop drops the entry and sets overflow. The frame is still counted by checksum; the remainder of the frame is still pushed if space frees.
  - Write and read pointers wrap modulo FIFO_DEPTH.
- Counters saturate at all-ones.
- clear_stats:
  - Zeroes good_frames, bad_frames and overflow the next cycle.
  - If it coincides with a frame-completion increment, the clear wins.
  - It does not affect the FSM or the FIFO.
- Latency: the last payload byte becomes visible 2 cycles after the final CSUM bit (1 cycle push, 1 cycle registered out); other bytes become visible 2 cycles after their last bit.

Test Plan:
- Reset, then bit_valid=1, SYNC, LEN=3, bytes 11,22,33, CSUM=69, out_ready=1:
  - Output is 11(sop), 22, 33(eop, err=0).
  - good_frames=1, led_readdata=01.
- Same frame with CSUM=00: bytes 11, 22, 33 are output, 33 carries eop with err=1; bad_frames=1, good_frames unchanged.
- LEN=0, CSUM=00: no Avalon-ST beat; good_frames increments. Then LEN=1, byte 7F, CSUM=80: a single beat with sop=eop=1.
- out_ready=0, a frame with LEN=20 (FIFO_DEPTH=16):
  - 16 entries are held and overflow=1.
  - Raising out_ready drains the 16 in order.
  - clear_stats then zeroes overflow, good_frames and bad_frames.
- bit_valid toggling 1-of-4 cycles with a random pre-sync noise prefix and an LEN=2 frame: output is identical to the bit_valid=1 case, and locked rises on the sync match.
- reset_reset_n pulsed low mid-PAYLOAD: all outputs 0 the next cycle and no partial frame is emitted. The next complete frame is received correctly.
